mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the five-stage pipeline.
- Consumes the EX/MEM register outputs and performs loads and stores over a req/ack data-memory bus, with byte/half/word lane alignment.
- Selects the writeback value and registers the MEM/WB pipeline outputs.
- Stalls upstream while an access is outstanding; aborts an access after a timeout.

Parameters:
TIMEOUT_CYCLES, 16, cycles waiting for dmem_ack before abort (min 1)
XLEN, 32, datapath width (only 32 supported)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
alu_result_in  in  32  effective address / ALU value
rs2_in  in  32  store data
rd_in  in  5  destination register
mem_funct3_in  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
mem_read_in  in  1  load
mem_write_in  in  1  store
mem_to_reg_in  in  1  writeback selects load data
reg_write_in  in  1  register write enable
jal_in  in  1  writeback selects pc_plus4
jalr_in  in  1  writeback selects pc_plus4
is_lui_in  in  1  writeback selects imm
pc_plus4_in  in  32  link value
imm_in  in  32  LUI value
dmem_req  out  1  access request
dmem_we  out  1  1 = store
dmem_addr  out  32  word-aligned address {alu_result_in[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_wstrb  out  4  byte strobes (0 for loads)
dmem_ack  in  1  access complete; rdata valid on loads
dmem_rdata  in  32  load word
stall_out  out  1  hold PC/IF/ID/EX/MEM registers
wb_data_out  out  32  registered writeback value
rd_out  out  5  registered rd
reg_write_out  out  1  registered write enable
misaligned_out  out  1  registered 1-cycle pulse: misaligned access dropped
mem_err_out  out  1  registered 1-cycle pulse: timeout abort

Behaviour:
- Reset: state IDLE, timeout counter 0, all registered outputs 0. dmem_req and stall_out are forced 0 while reset is high.
- mem_op = mem_read_in | mem_write_in. If both are high, treat the access as a store.
- Alignment rules:
  - Half access needs addr[0]=0.
  - Word access needs addr[1:0]=0.
  - Byte access is always aligned.
  - funct3 011, 110 or 111: treated as word.
- Misaligned access:
  - No dmem_req is issued and no stall occurs.
  - MEM/WB captures reg_write_out=0 and misaligned_out=1.
- States:
  - IDLE: if mem_op and aligned, dmem_req=1 combinationally.
    - dmem_ack in the same cycle: complete, stall_out=0.
    - Otherwise: stall_out=1, go to WAIT, counter=1.
  - WAIT: dmem_req=1, stall_out=1, request fields driven from the held EX/MEM inputs.
    - dmem_ack: complete, stall_out=0, go to IDLE.
    - Else if counter==TIMEOUT_CYCLES: abort. dmem_req=0 and stall_out=0 this cycle; MEM/WB captures reg_write_out=0 and mem_err_out=1; go to IDLE.
    - Else: counter increments.
- dmem_ack is ignored in IDLE when no request is active, and ignored after an abort.
- Store lanes:
  - sb: wdata={4{rs2[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - sh: wdata={2{rs2[15:0]}}, wstrb=addr[1]?1100:0011.
  - sw: wdata=rs2, wstrb=1111.
- Load extract:
  - Select the byte or half from dmem_rdata by addr[1:0].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
- Writeback select, in priority order: jal|jalr -> pc_plus4_in; is_lui_in -> imm_in; mem_to_reg_in -> load data; else alu_result_in.
- MEM/WB register:
  - Updates every cycle that stall_out=0.
  - While stall_out=1 it loads a bubble: reg_write_out=0, rd_out=0, pulses 0.
- Latency: non-memory instruction 1 cycle to MEM/WB. Memory access N+1 cycles, where N is the ack wait.
- A store completes with the register write gated by reg_write_in (normally 0).
- Reset asserted mid-WAIT: return to IDLE next edge, request abandoned, no pulse generated.

Decomposition:
- Package mem_pkg:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - State encoding ST_IDLE/ST_WAIT.
  - Writeback-select priority documented alongside.
- Sub-module load_store_align (purely combinational):
  - Inputs: funct3, addr[1:0], rs2, rdata.
  - Outputs: wdata, wstrb, load_data, aligned.

Test Plan:
- ALU op, alu_result_in=0x1234, reg_write_in=1, rd=5 -> next cycle wb_data_out=0x1234, rd_out=5, reg_write_out=1, no dmem_req.
- sb, addr=0x103, rs2=0xAB, ack after 2 cycles -> dmem_addr=0x100, wstrb=1000, wdata=0xABABABAB, stall_out high exactly 2 cycles.
- lb/lbu, addr=0x102, rdata=0x00800000, same-cycle ack -> wb_data_out=0xFFFFFF80 / 0x00000080, no stall.
- lw at addr=0x102 -> no dmem_req, misaligned_out=1 for one cycle, reg_write_out=0.
- lw, ack never asserted, TIMEOUT_CYCLES=4 -> stall for 4 cycles, mem_err_out pulse, reg_write_out=0, late ack ignored.
- jal with pc_plus4=0x40, then reset asserted mid-WAIT of the following load -> wb_data_out=0x40; after reset all outputs 0, dmem_req=0 during reset.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_pkg: shared definitions for the memory-access pipeline stage.
//   - funct3 access-size/sign encodings
//   - access FSM state type
//   - writeback-select helper (fixed priority, see wb_select)
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    // Writeback priority, highest first:
    //   jal | jalr  -> pc_plus4
    //   is_lui      -> imm
    //   mem_to_reg  -> load data
    //   otherwise   -> ALU result
    function automatic logic [31:0] wb_select(
        input logic        link,
        input logic        lui,
        input logic        mem_to_reg,
        input logic [31:0] pc_plus4,
        input logic [31:0] imm,
        input logic [31:0] load_data,
        input logic [31:0] alu_result
    );
        if (link)            return pc_plus4;
        else if (lui)        return imm;
        else if (mem_to_reg) return load_data;
        else                 return alu_result;
    endfunction

endpackage

// File: rtl/mem_stage_load_store_align.sv
// load_store_align: combinational byte-lane steering for the data bus.
//   funct3    : access size/sign (F3_* encodings; 011/110/111 act as word)
//   addr_lo   : low two address bits
//   rs2       : store data
//   rdata     : load word from memory
//   wdata     : lane-replicated store data
//   wstrb     : byte strobes for a store of this size at this address
//   load_data : extracted and sign/zero-extended load value
//   aligned   : access size is naturally aligned at addr_lo
module load_store_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data,
    output logic        aligned
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic        is_unsigned;

    assign rd_byte     = rdata[{addr_lo, 3'b000} +: 8];
    assign rd_half     = rdata[{addr_lo[1], 4'b0000} +: 16];
    assign is_unsigned = funct3[2];

    always_comb begin
        wdata     = rs2;
        wstrb     = 4'b1111;
        load_data = rdata;
        aligned   = (addr_lo == 2'b00);
        // Size lives in funct3[1:0]; 2'b10 and 2'b11 both fall through as word.
        case (funct3[1:0])
            F3_B[1:0]: begin
                wdata     = {4{rs2[7:0]}};
                wstrb     = 4'b0001 << addr_lo;
                load_data = is_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                aligned   = 1'b1;
            end
            F3_H[1:0]: begin
                wdata     = {2{rs2[15:0]}};
                wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
                load_data = is_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
                aligned   = ~addr_lo[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage pipeline.
//   EX/MEM inputs : alu_result_in, rs2_in, rd_in, mem_funct3_in, mem_read_in,
//                   mem_write_in, mem_to_reg_in, reg_write_in, jal_in, jalr_in,
//                   is_lui_in, pc_plus4_in, imm_in
//   data bus      : dmem_req/we/addr/wdata/wstrb out, dmem_ack/rdata in
//   stall_out     : holds upstream pipeline registers while an access waits
//   MEM/WB outputs: wb_data_out, rd_out, reg_write_out,
//                   misaligned_out / mem_err_out (1-cycle pulses)
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned XLEN           = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] rs2_in,
    input  logic [4:0]      rd_in,
    input  logic [2:0]      mem_funct3_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic            mem_to_reg_in,
    input  logic            reg_write_in,
    input  logic            jal_in,
    input  logic            jalr_in,
    input  logic            is_lui_in,
    input  logic [XLEN-1:0] pc_plus4_in,
    input  logic [XLEN-1:0] imm_in,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stall_out,
    output logic [XLEN-1:0] wb_data_out,
    output logic [4:0]      rd_out,
    output logic            reg_write_out,
    output logic            misaligned_out,
    output logic            mem_err_out
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            mem_op;
    logic            aligned;
    logic [31:0]     align_wdata;
    logic [3:0]      align_wstrb;
    logic [31:0]     load_data;
    logic [31:0]     wb_value;

    logic            req;
    logic            stall;
    logic            misaligned;
    logic            abort;

    assign mem_op = mem_read_in | mem_write_in;

    load_store_align u_align (
        .funct3    (mem_funct3_in),
        .addr_lo   (alu_result_in[1:0]),
        .rs2       (rs2_in),
        .rdata     (dmem_rdata),
        .wdata     (align_wdata),
        .wstrb     (align_wstrb),
        .load_data (load_data),
        .aligned   (aligned)
    );

    assign wb_value = wb_select(jal_in | jalr_in, is_lui_in, mem_to_reg_in,
                                pc_plus4_in, imm_in, load_data, alu_result_in);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req        = 1'b0;
        stall      = 1'b0;
        misaligned = 1'b0;
        abort      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    if (aligned) begin
                        req = 1'b1;
                        if (!dmem_ack) begin
                            stall   = 1'b1;
                            state_d = ST_WAIT;
                            cnt_d   = CW'(1);
                        end
                    end else begin
                        misaligned = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                req = 1'b1;
                if (dmem_ack) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
                    // Abort drops the request in the same cycle so a late ack
                    // can never be matched to this access.
                    req     = 1'b0;
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign dmem_req   = req & ~reset;
    assign stall_out  = stall & ~reset;
    assign dmem_we    = dmem_req & mem_write_in;
    assign dmem_addr  = {alu_result_in[XLEN-1:2], 2'b00};
    assign dmem_wdata = align_wdata;
    assign dmem_wstrb = dmem_we ? align_wstrb : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            wb_data_out    <= '0;
            rd_out         <= '0;
            reg_write_out  <= 1'b0;
            misaligned_out <= 1'b0;
            mem_err_out    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall) begin
                wb_data_out    <= '0;
                rd_out         <= '0;
                reg_write_out  <= 1'b0;
                misaligned_out <= 1'b0;
                mem_err_out    <= 1'b0;
            end else begin
                wb_data_out    <= wb_value;
                rd_out         <= rd_in;
                reg_write_out  <= reg_write_in & ~misaligned & ~abort;
                misaligned_out <= misaligned;
                mem_err_out    <= abort;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_result_in, rs2_in, pc_plus4_in, imm_in;
    logic [4:0]  rd_in;
    logic [2:0]  mem_funct3_in;
    logic        mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in;
    logic        jal_in, jalr_in, is_lui_in;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        stall_out;
    logic [31:0] wb_data_out;
    logic [4:0]  rd_out;
    logic        reg_write_out, misaligned_out, mem_err_out;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(T), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .alu_result_in(alu_result_in), .rs2_in(rs2_in), .rd_in(rd_in),
        .mem_funct3_in(mem_funct3_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
        .reg_write_in(reg_write_in), .jal_in(jal_in), .jalr_in(jalr_in),
        .is_lui_in(is_lui_in), .pc_plus4_in(pc_plus4_in), .imm_in(imm_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_out(stall_out), .wb_data_out(wb_data_out), .rd_out(rd_out),
        .reg_write_out(reg_write_out), .misaligned_out(misaligned_out),
        .mem_err_out(mem_err_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int access_bytes(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] word);
        int n;
        logic [31:0] v, mask;
        n = access_bytes(f3);
        if (n == 4) return word;
        mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = (word >> (8 * (a % 4))) & mask;
        if ((f3 == 3'b000 || f3 == 3'b001) && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] model_strb(input int n, input logic [31:0] a);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input int n, input logic [31:0] d);
        if (n == 1) return {24'd0, d[7:0]} * 32'h0101_0101;
        if (n == 2) return {16'd0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_wb();
        if (jal_in || jalr_in) return pc_plus4_in;
        if (is_lui_in)         return imm_in;
        if (mem_to_reg_in)     return model_load(mem_funct3_in, alu_result_in, dmem_rdata);
        return alu_result_in;
    endfunction

    task automatic set_nop();
        alu_result_in = '0; rs2_in = '0; pc_plus4_in = '0; imm_in = '0; rd_in = '0;
        mem_funct3_in = 3'b010; mem_read_in = 0; mem_write_in = 0; mem_to_reg_in = 0;
        reg_write_in = 0; jal_in = 0; jalr_in = 0; is_lui_in = 0;
        dmem_ack = 0; dmem_rdata = '0;
    endtask

    // Called at a negedge with the instruction fields already set. Runs the
    // instruction to completion and returns at the negedge after MEM/WB loads.
    // ack_at: request cycle in which dmem_ack is raised (<0 or >T: never).
    task automatic run_txn(input string name, input int ack_at);
        int n, last;
        bit is_mem, ok, acked, is_store;
        logic [31:0] exp_wb;
        n        = access_bytes(mem_funct3_in);
        is_mem   = mem_read_in | mem_write_in;
        is_store = mem_write_in;
        ok       = (alu_result_in % n) == 0;
        acked    = ack_at >= 0 && ack_at <= T;
        last     = (!is_mem || !ok) ? 0 : (acked ? ack_at : T);
        exp_wb   = model_wb();
        for (int k = 0; k <= last; k++) begin
            dmem_ack = (k == ack_at);
            #1;
            check({name, ".req"},   32'(dmem_req),  32'(is_mem && ok && (acked || k < T)));
            check({name, ".stall"}, 32'(stall_out), 32'(is_mem && ok && k < last));
            if (is_mem && ok && k == 0) begin
                check({name, ".addr"}, dmem_addr, alu_result_in & 32'hFFFF_FFFC);
                check({name, ".we"},   32'(dmem_we), 32'(is_store));
                check({name, ".strb"}, 32'(dmem_wstrb), is_store ? 32'(model_strb(n, alu_result_in)) : 32'd0);
                if (is_store) check({name, ".wdata"}, dmem_wdata, model_wdata(n, rs2_in));
            end
            @(negedge clk);
            if (k < last) begin
                check({name, ".bub_rw"}, 32'(reg_write_out), 32'd0);
                check({name, ".bub_rd"}, 32'(rd_out), 32'd0);
                check({name, ".bub_pl"}, 32'({misaligned_out, mem_err_out}), 32'd0);
            end
        end
        dmem_ack = 0;
        if (is_mem && !ok) begin
            check({name, ".rw"},  32'(reg_write_out), 32'd0);
            check({name, ".mis"}, 32'(misaligned_out), 32'd1);
            check({name, ".err"}, 32'(mem_err_out), 32'd0);
        end else if (is_mem && !acked) begin
            check({name, ".rw"},  32'(reg_write_out), 32'd0);
            check({name, ".mis"}, 32'(misaligned_out), 32'd0);
            check({name, ".err"}, 32'(mem_err_out), 32'd1);
        end else begin
            check({name, ".rw"},  32'(reg_write_out), 32'(reg_write_in));
            check({name, ".rd"},  32'(rd_out), 32'(rd_in));
            check({name, ".wb"},  wb_data_out, exp_wb);
            check({name, ".pul"}, 32'({misaligned_out, mem_err_out}), 32'd0);
        end
    endtask

    initial begin
        logic [2:0] f3_tab [8];
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

        // Reset with a valid load presented: request and stall must stay low.
        set_nop();
        reset = 1;
        mem_read_in = 1; mem_to_reg_in = 1; reg_write_in = 1; rd_in = 5'd9;
        @(negedge clk); #1;
        check("rst.req",   32'(dmem_req), 32'd0);
        check("rst.stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        check("rst.outs", {wb_data_out[26:0], rd_out}, 32'd0);
        check("rst.flags", 32'({reg_write_out, misaligned_out, mem_err_out}), 32'd0);
        set_nop();
        reset = 0;

        // ALU op
        alu_result_in = 32'h1234; reg_write_in = 1; rd_in = 5'd5;
        run_txn("alu", -1);
        // sb at 0x103, ack after two wait cycles
        set_nop();
        alu_result_in = 32'h103; rs2_in = 32'hAB; mem_write_in = 1; mem_funct3_in = 3'b000;
        run_txn("sb", 2);
        // lb / lbu at 0x102 with same-cycle ack
        set_nop();
        alu_result_in = 32'h102; dmem_rdata = 32'h0080_0000; mem_read_in = 1;
        mem_to_reg_in = 1; reg_write_in = 1; rd_in = 5'd7; mem_funct3_in = 3'b000;
        run_txn("lb", 0);
        check("lb.val", wb_data_out, 32'hFFFF_FF80);
        mem_funct3_in = 3'b100;
        run_txn("lbu", 0);
        check("lbu.val", wb_data_out, 32'h0000_0080);
        // misaligned lw
        mem_funct3_in = 3'b010;
        run_txn("lw_mis", 0);
        // lw timeout, then a stray ack on a nop
        alu_result_in = 32'h200;
        run_txn("lw_to", -1);
        set_nop();
        alu_result_in = 32'h55; reg_write_in = 1; rd_in = 5'd3;
        run_txn("late_ack", 0);
        // jal, then reset in the middle of a waiting load
        set_nop();
        jal_in = 1; pc_plus4_in = 32'h40; alu_result_in = 32'h999; reg_write_in = 1; rd_in = 5'd1;
        run_txn("jal", -1);
        check("jal.val", wb_data_out, 32'h40);
        set_nop();
        alu_result_in = 32'h300; mem_read_in = 1; mem_to_reg_in = 1; reg_write_in = 1; rd_in = 5'd4;
        #1; check("rstw.req0", 32'(dmem_req), 32'd1);
        @(negedge clk); @(negedge clk);
        reset = 1;
        #1;
        check("rstw.req",   32'(dmem_req), 32'd0);
        check("rstw.stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        check("rstw.wb", wb_data_out, 32'd0);
        check("rstw.flags", 32'({rd_out, reg_write_out, misaligned_out, mem_err_out}), 32'd0);
        reset = 0;
        set_nop();
        #1; check("rstw.idle", 32'({dmem_req, stall_out}), 32'd0);
        @(negedge clk);
        check("rstw.nopulse", 32'({reg_write_out, mem_err_out, misaligned_out}), 32'd0);

        // Randomized instruction stream
        for (int i = 0; i < 200; i++) begin
            int kind, ack_at;
            set_nop();
            kind          = int'($urandom_range(0, 2));
            alu_result_in = $urandom;
            if ($urandom_range(0, 2) != 0) alu_result_in[1:0] = 2'b00;
            rs2_in        = $urandom;
            dmem_rdata    = $urandom;
            pc_plus4_in   = $urandom;
            imm_in        = $urandom;
            rd_in         = 5'($urandom);
            mem_funct3_in = f3_tab[$urandom_range(0, 7)];
            ack_at        = int'($urandom_range(0, T + 2));
            if (kind == 0) begin
                reg_write_in = 1'($urandom);
                jal_in       = ($urandom_range(0, 4) == 0);
                jalr_in      = ($urandom_range(0, 4) == 0);
                is_lui_in    = ($urandom_range(0, 3) == 0);
                ack_at       = ($urandom_range(0, 1) == 0) ? 0 : -1;
                run_txn("rnd_alu", ack_at);
            end else if (kind == 1) begin
                mem_read_in = 1; mem_to_reg_in = 1; reg_write_in = 1;
                run_txn("rnd_ld", ack_at);
            end else begin
                mem_write_in = 1; mem_read_in = 1'($urandom);
                reg_write_in = ($urandom_range(0, 5) == 0);
                run_txn("rnd_st", ack_at);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
